// File: rtl/hit_edge_pkg.sv
// Shared types and constants for the ball hit-edge detector.
// Edge bits are ball-relative: left, top, right, bottom.
package hit_edge_pkg;

    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

    typedef logic [3:0] edge_code_t;

    typedef enum logic {
        ACCUM   = 1'b0,
        HOLDOFF = 1'b1
    } state_t;

    // Unsigned scan coordinate minus signed ball corner, 12-bit signed.
    function automatic logic signed [11:0] pix_offset(
        input logic        [10:0] pix,
        input logic signed [10:0] corner
    );
        return $signed({1'b0, pix}) - $signed({corner[10], corner});
    endfunction

endpackage

// File: rtl/edge_band_classifier.sv
// Maps a ball-relative pixel offset to its in-box flag and edge bands.
// Corner pixels set two bits; interior pixels set none.
module edge_band_classifier
    import hit_edge_pkg::*;
#(
    parameter int OBJECT_WIDTH_X  = 64,
    parameter int OBJECT_HEIGHT_Y = 64,
    parameter int EDGE_MARGIN     = 4
) (
    input  logic signed [11:0] offX,
    input  logic signed [11:0] offY,
    output logic               inBox,
    output edge_code_t         edgeCode
);

    logic w_inX;
    logic w_inY;
    logic [10:0] w_magX;
    logic [10:0] w_magY;

    // Magnitudes are only meaningful once the sign bit is known clear.
    assign w_magX = offX[10:0];
    assign w_magY = offY[10:0];

    assign w_inX = !offX[11] && (w_magX < 11'(OBJECT_WIDTH_X));
    assign w_inY = !offY[11] && (w_magY < 11'(OBJECT_HEIGHT_Y));
    assign inBox = w_inX && w_inY;

    always_comb begin
        edgeCode = '0;
        if (inBox) begin
            edgeCode[EDGE_LEFT] =
                w_magX < 11'(EDGE_MARGIN);
            edgeCode[EDGE_TOP] =
                w_magY < 11'(EDGE_MARGIN);
            edgeCode[EDGE_RIGHT] =
                w_magX >= 11'(OBJECT_WIDTH_X - EDGE_MARGIN);
            edgeCode[EDGE_BOTTOM] =
                w_magY >= 11'(OBJECT_HEIGHT_Y - EDGE_MARGIN);
        end
    end

endmodule

// File: rtl/ball_hit_edge_detector.sv
// Accumulates ball/obstacle edge overlaps over a frame and reports
// them as a one-cycle pulse at the next start of frame.
module ball_hit_edge_detector
    import hit_edge_pkg::*;
#(
    parameter int OBJECT_WIDTH_X  = 64,
    parameter int OBJECT_HEIGHT_Y = 64,
    parameter int EDGE_MARGIN     = 4,
    parameter int HOLDOFF_FRAMES  = 2,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic [10:0]            pixelX,
    input  logic [10:0]            pixelY,
    input  logic signed [10:0]     topLeftX,
    input  logic signed [10:0]     topLeftY,
    input  logic                   ballDR,
    input  logic                   obstacleDR,
    output logic                   collision,
    output logic [3:0]             HitEdgeCode,
    output logic [COUNT_WIDTH-1:0] collisionCount
);

    localparam int HW = (HOLDOFF_FRAMES > 1) ?
                        $clog2(HOLDOFF_FRAMES + 1) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_FRAMES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic signed [11:0] w_offX;
    logic signed [11:0] w_offY;
    logic               w_inBox;
    edge_code_t         w_code;
    edge_code_t         w_band;

    state_t     r_state;
    edge_code_t r_acc;
    logic [HW-1:0] r_hold;

    assign w_offX = pix_offset(pixelX, topLeftX);
    assign w_offY = pix_offset(pixelY, topLeftY);

    edge_band_classifier #(
        .OBJECT_WIDTH_X  (OBJECT_WIDTH_X),
        .OBJECT_HEIGHT_Y (OBJECT_HEIGHT_Y),
        .EDGE_MARGIN     (EDGE_MARGIN)
    ) u_classifier (
        .offX     (w_offX),
        .offY     (w_offY),
        .inBox    (w_inBox),
        .edgeCode (w_code)
    );

    assign w_band = (ballDR && obstacleDR && w_inBox) ? w_code : '0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state        <= ACCUM;
            r_acc          <= '0;
            r_hold         <= '0;
            collision      <= 1'b0;
            HitEdgeCode    <= '0;
            collisionCount <= '0;
        end else begin
            collision <= 1'b0;
            unique case (r_state)
                ACCUM: begin
                    if (!startOfFrame) begin
                        r_acc <= r_acc | w_band;
                    end else if (r_acc == '0) begin
                        r_acc <= w_band;
                    end else begin
                        // Report the finished frame; the SOF-cycle
                        // overlap starts the next one.
                        collision   <= 1'b1;
                        HitEdgeCode <= r_acc;
                        if (collisionCount != CNT_MAX) begin
                            collisionCount <= collisionCount + 1'b1;
                        end
                        if (HOLDOFF_FRAMES > 0) begin
                            r_state <= HOLDOFF;
                            r_hold  <= HOLD_INIT;
                            r_acc   <= '0;
                        end else begin
                            r_acc <= w_band;
                        end
                    end
                end
                HOLDOFF: begin
                    r_acc <= '0;
                    if (startOfFrame) begin
                        r_hold <= r_hold - HOLD_LAST;
                        if (r_hold == HOLD_LAST) begin
                            r_state <= ACCUM;
                        end
                    end
                end
                default: begin
                    r_state <= ACCUM;
                    r_acc   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_hit_edge_detector.sv
// Bench for ball_hit_edge_detector: directed table, corner sequences
// and randomized frames against a frame-level reference model.
module tb_ball_hit_edge_detector;

    localparam int W  = 64;
    localparam int H  = 64;
    localparam int M  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetN, sof, bdr, odr;
    logic [10:0] px, py;
    logic signed [10:0] tlx, tly;

    logic       col_a, col_b;
    logic [3:0] hec_a, hec_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    ball_hit_edge_detector #(
        .OBJECT_WIDTH_X(W), .OBJECT_HEIGHT_Y(H), .EDGE_MARGIN(M),
        .HOLDOFF_FRAMES(2), .COUNT_WIDTH(8)
    ) dut_a (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .pixelX(px), .pixelY(py), .topLeftX(tlx), .topLeftY(tly),
        .ballDR(bdr), .obstacleDR(odr),
        .collision(col_a), .HitEdgeCode(hec_a), .collisionCount(cnt_a)
    );

    ball_hit_edge_detector #(
        .OBJECT_WIDTH_X(W), .OBJECT_HEIGHT_Y(H), .EDGE_MARGIN(M),
        .HOLDOFF_FRAMES(0), .COUNT_WIDTH(2)
    ) dut_b (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .pixelX(px), .pixelY(py), .topLeftX(tlx), .topLeftY(tly),
        .ballDR(bdr), .obstacleDR(odr),
        .collision(col_b), .HitEdgeCode(hec_b), .collisionCount(cnt_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model, one slot per DUT: what the current frame has
    // seen, how many frames are still skipped, and the report history.
    int frame_bits[2];
    int skip_left[2];
    int reports[2];
    int last_code[2];
    int pulse[2];
    int skip_cfg[2] = '{2, 0};
    int cnt_max[2]  = '{255, 3};

    typedef struct {
        bit s;
        int x, y, tx, ty;
        bit b, o;
        bit ec;
        int eh;
        int en;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t v(bit s, int x, int y, int tx, int ty,
                               bit b, bit o, bit ec, int eh, int en);
        vec_t r;
        r.s = s; r.x = x; r.y = y; r.tx = tx; r.ty = ty;
        r.b = b; r.o = o; r.ec = ec; r.eh = eh; r.en = en;
        return r;
    endfunction

    function automatic int bands(int x, int y, int tx, int ty,
                                 bit b, bit o);
        int dx, dy, r;
        dx = x - tx;
        dy = y - ty;
        if (!(b && o)) return 0;
        if (dx < 0 || dx >= W || dy < 0 || dy >= H) return 0;
        r = 0;
        if (dx < M)      r += 8;
        if (dy < M)      r += 4;
        if (dx >= W - M) r += 2;
        if (dy >= H - M) r += 1;
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            frame_bits[d] = 0; skip_left[d] = 0;
            reports[d] = 0; last_code[d] = 0; pulse[d] = 0;
        end
    endtask

    task automatic model_step(bit s, int x, int y, int tx, int ty,
                              bit b, bit o);
        int nb;
        nb = bands(x, y, tx, ty, b, o);
        for (int d = 0; d < 2; d++) begin
            pulse[d] = 0;
            if (skip_left[d] > 0) begin
                if (s) skip_left[d]--;
            end else if (!s) begin
                frame_bits[d] |= nb;
            end else begin
                if (frame_bits[d] != 0) begin
                    pulse[d] = 1;
                    last_code[d] = frame_bits[d];
                    if (reports[d] < cnt_max[d]) reports[d]++;
                    skip_left[d] = skip_cfg[d];
                end
                frame_bits[d] = (skip_left[d] > 0) ? 0 : nb;
            end
        end
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(bit s, int x, int y, int tx, int ty,
                       bit b, bit o);
        sof = s; px = 11'(x); py = 11'(y);
        tlx = 11'(tx); tly = 11'(ty); bdr = b; odr = o;
        model_step(s, x, y, tx, ty, b, o);
        @(posedge clk);
        #1;
        check("model_col_a", int'(col_a), pulse[0]);
        check("model_hec_a", int'(hec_a), last_code[0]);
        check("model_cnt_a", int'(cnt_a), reports[0]);
        check("model_col_b", int'(col_b), pulse[1]);
        check("model_hec_b", int'(hec_b), last_code[1]);
        check("model_cnt_b", int'(cnt_b), reports[1]);
    endtask

    task automatic reset_dut();
        resetN = 1'b0;
        sof = 0; px = '0; py = '0; tlx = '0; tly = '0;
        bdr = 0; odr = 0;
        model_reset();
        #1;
        check("rst_col_a", int'(col_a), 0);
        check("rst_hec_a", int'(hec_a), 0);
        check("rst_cnt_a", int'(cnt_a), 0);
        check("rst_cnt_b", int'(cnt_b), 0);
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        int tx, ty;
        tbl[0]  = v(1,   0,   0, 280, 185, 0, 0, 0, 0, 0);
        tbl[1]  = v(0, 281, 200, 280, 185, 1, 1, 0, 0, 0);
        tbl[2]  = v(0, 281, 200, 280, 185, 1, 0, 0, 0, 0);
        tbl[3]  = v(1,   0,   0, 280, 185, 0, 0, 1, 8, 1);
        tbl[4]  = v(0,   0,   0, 280, 185, 0, 0, 0, 8, 1);
        tbl[5]  = v(1, 281, 200, 280, 185, 1, 1, 0, 8, 1);
        tbl[6]  = v(1,   0,   0, 280, 185, 0, 0, 0, 8, 1);
        tbl[7]  = v(0, 343, 248, 280, 185, 1, 1, 0, 8, 1);
        tbl[8]  = v(1,   0,   0, 280, 185, 0, 0, 1, 3, 2);
        tbl[9]  = v(1,   0,   0, 280, 185, 0, 0, 0, 3, 2);
        tbl[10] = v(1,   0,   0, 280, 185, 0, 0, 0, 3, 2);
        tbl[11] = v(0, 300, 210, 280, 185, 1, 1, 0, 3, 2);
        tbl[12] = v(1,   0,   0, 280, 185, 0, 0, 0, 3, 2);
        tbl[13] = v(0,   0, 130, -10, 100, 1, 1, 0, 3, 2);
        tbl[14] = v(0,  60, 130, -10, 100, 1, 1, 0, 3, 2);
        tbl[15] = v(1,   0,   0, -10, 100, 0, 0, 0, 3, 2);
        tbl[16] = v(0,  51, 130, -10, 100, 1, 1, 0, 3, 2);
        tbl[17] = v(1,   0,   0, -10, 100, 0, 0, 1, 2, 3);
        tbl[18] = v(1,   0,   0, -10, 100, 0, 0, 0, 2, 3);
        tbl[19] = v(1,   0,   0, -10, 100, 0, 0, 0, 2, 3);
        tbl[20] = v(1, 300, 248, 280, 185, 1, 1, 0, 2, 3);
        tbl[21] = v(0,   0,   0, 280, 185, 0, 0, 0, 2, 3);
        tbl[22] = v(1,   0,   0, 280, 185, 0, 0, 1, 1, 4);

        reset_dut();
        for (int i = 0; i < 23; i++) begin
            cyc(tbl[i].s, tbl[i].x, tbl[i].y, tbl[i].tx, tbl[i].ty,
                tbl[i].b, tbl[i].o);
            check($sformatf("tbl%0d_col", i), int'(col_a), int'(tbl[i].ec));
            check($sformatf("tbl%0d_hec", i), int'(hec_a), tbl[i].eh);
            check($sformatf("tbl%0d_cnt", i), int'(cnt_a), tbl[i].en);
        end

        // Left-band overlap every frame: holdoff spaces reports by 3.
        reset_dut();
        for (int k = 1; k <= 7; k++) begin
            cyc(0, 281, 200, 280, 185, 1, 1);
            cyc(1,   0,   0, 280, 185, 0, 0);
            check($sformatf("hold_k%0d", k), int'(col_a),
                  (k == 1 || k == 4 || k == 7) ? 1 : 0);
            check($sformatf("nohold_k%0d", k), int'(col_b), 1);
        end
        check("sat_cnt_b", int'(cnt_b), 3);
        check("hold_cnt_a", int'(cnt_a), 3);
        cyc(0, 281, 200, 280, 185, 1, 1);
        cyc(1,   0,   0, 280, 185, 0, 0);
        check("sat_stay_b", int'(cnt_b), 3);

        // Asynchronous reset in the middle of a frame with a pending hit.
        cyc(0, 281, 200, 280, 185, 1, 1);
        #3;
        resetN = 1'b0;
        model_reset();
        #1;
        check("midrst_col_a", int'(col_a), 0);
        check("midrst_hec_a", int'(hec_a), 0);
        check("midrst_cnt_a", int'(cnt_a), 0);
        check("midrst_cnt_b", int'(cnt_b), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        cyc(1, 0, 0, 280, 185, 0, 0);
        check("midrst_nopulse", int'(col_a), 0);

        // Random frames against the model.
        reset_dut();
        tx = 0; ty = 0;
        for (int i = 0; i < 3000; i++) begin
            bit s;
            s = (i % 40) == 39;
            if (i % 40 == 0) begin
                tx = int'($urandom_range(140)) - 20;
                ty = int'($urandom_range(140)) - 20;
            end
            cyc(s, int'($urandom_range(200)), int'($urandom_range(200)),
                tx, ty, 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
